// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and widths for the voice allocator and its
//                per-voice slots.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    // Per-voice lifecycle state
    typedef enum logic [1:0] {
        VS_FREE      = 2'd0,
        VS_HELD      = 2'd1,
        VS_RELEASING = 2'd2
    } voiceState_t;

    // Allocator controller state
    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_SCAN   = 2'd1,
        FSM_COMMIT = 2'd2
    } allocState_t;

endpackage
`default_nettype wire

// File: rtl/voice_allocator_voice_slot.sv
`default_nettype none
// ============================================================================
//  Module      : voice_slot
//  Description : One voice of the allocator: lifecycle state, note/velocity
//                registers, saturating age counter and retrigger pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_slot
    import synth_pkg::*;
#(
    parameter int AGE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_write,
    input  logic              i_ageInc,
    input  logic              i_release,
    input  logic              i_panic,
    input  logic              i_releaseDone,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [VEL_W-1:0]  i_velocity,
    output voiceState_t       o_state,
    output logic [NOTE_W-1:0] o_note,
    output logic [VEL_W-1:0]  o_velocity,
    output logic [AGE_W-1:0]  o_age,
    output logic              o_gate,
    output logic              o_trig
);

    localparam logic [AGE_W-1:0] c_ageMax = {AGE_W{1'b1}};

    voiceState_t       r_state;
    logic [NOTE_W-1:0] r_note;
    logic [VEL_W-1:0]  r_velocity;
    logic [AGE_W-1:0]  r_age;
    logic              r_trig;

    // Voice update; panic on a held key beats everything, a commit beats a
    // simultaneous release_done, release_done only acts on a releasing voice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= VS_FREE;
            r_note     <= '0;
            r_velocity <= '0;
            r_age      <= '0;
            r_trig     <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            if (i_panic && (r_state == VS_HELD)) begin
                r_state <= VS_RELEASING;
            end else if (i_write) begin
                r_state    <= VS_HELD;
                r_note     <= i_note;
                r_velocity <= i_velocity;
                r_age      <= '0;
                r_trig     <= 1'b1;
            end else if ((r_state == VS_RELEASING) && i_releaseDone) begin
                r_state <= VS_FREE;
                r_age   <= '0;
            end else if (i_release && (r_state == VS_HELD)) begin
                r_state <= VS_RELEASING;
            end else if (i_ageInc && (r_state != VS_FREE) && (r_age != c_ageMax)) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    assign o_state    = r_state;
    assign o_note     = r_note;
    assign o_velocity = r_velocity;
    assign o_age      = r_age;
    assign o_gate     = (r_state == VS_HELD);
    assign o_trig     = r_trig;

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic voice scheduler. Accepts note-on/off events,
//                scans the voices one per cycle and commits the event to a
//                retriggered, free, oldest releasing or oldest held voice.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [VEL_W-1:0]             ev_velocity,
    input  logic                         panic,
    input  logic [NUM_VOICES-1:0]        release_done,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [VEL_W*NUM_VOICES-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [3:0]                   busy_count
);

    localparam int                c_idxW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [c_idxW-1:0] c_lastIdx = c_idxW'(NUM_VOICES - 1);

    allocState_t       r_state;
    allocState_t       w_nextState;
    logic              w_accept;
    logic              w_commit;

    // Latched event; velocity 0 on a note-on is folded into a note-off here
    logic              r_evOn;
    logic [NOTE_W-1:0] r_evNote;
    logic [VEL_W-1:0]  r_evVel;

    // Scan bookkeeping
    logic [c_idxW-1:0] r_scanIdx;
    logic              r_matchFound;
    logic [c_idxW-1:0] r_matchIdx;
    logic              r_freeFound;
    logic [c_idxW-1:0] r_freeIdx;
    logic              r_relFound;
    logic [c_idxW-1:0] r_relIdx;
    logic [AGE_W-1:0]  r_relAge;
    logic              r_heldFound;
    logic [c_idxW-1:0] r_heldIdx;
    logic [AGE_W-1:0]  r_heldAge;
    logic [c_idxW-1:0] w_target;

    // Per-slot views
    voiceState_t       w_slotState [NUM_VOICES];
    logic [NOTE_W-1:0] w_slotNote  [NUM_VOICES];
    logic [VEL_W-1:0]  w_slotVel   [NUM_VOICES];
    logic [AGE_W-1:0]  w_slotAge   [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_write;
    logic [NUM_VOICES-1:0] w_ageInc;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] w_gate;
    logic [NUM_VOICES-1:0] w_trig;

    voiceState_t       w_scanState;
    logic [NOTE_W-1:0] w_scanNote;
    logic [AGE_W-1:0]  w_scanAge;

    logic [4:0]        w_busy;
    logic [3:0]        r_busyCount;

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FSM_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Controller next state and strobes; panic abandons any event in flight
    always_comb begin
        w_nextState = r_state;
        ev_ready    = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            FSM_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = FSM_SCAN;
                end
            end
            FSM_SCAN: begin
                if (r_scanIdx == c_lastIdx) begin
                    w_nextState = FSM_COMMIT;
                end
            end
            FSM_COMMIT: begin
                w_commit    = 1'b1;
                w_nextState = FSM_IDLE;
            end
            default: begin
                w_nextState = FSM_IDLE;
            end
        endcase
        if (panic && (r_state != FSM_IDLE)) begin
            w_commit    = 1'b0;
            w_nextState = FSM_IDLE;
        end
    end

    assign w_scanState = w_slotState[r_scanIdx];
    assign w_scanNote  = w_slotNote[r_scanIdx];
    assign w_scanAge   = w_slotAge[r_scanIdx];

    // Event latch and one-voice-per-cycle scan; strict age compare keeps the
    // lowest index on ties because voices are visited in ascending order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evOn       <= 1'b0;
            r_evNote     <= '0;
            r_evVel      <= '0;
            r_scanIdx    <= '0;
            r_matchFound <= 1'b0;
            r_matchIdx   <= '0;
            r_freeFound  <= 1'b0;
            r_freeIdx    <= '0;
            r_relFound   <= 1'b0;
            r_relIdx     <= '0;
            r_relAge     <= '0;
            r_heldFound  <= 1'b0;
            r_heldIdx    <= '0;
            r_heldAge    <= '0;
        end else if (w_accept) begin
            r_evOn       <= ev_note_on && (ev_velocity != '0);
            r_evNote     <= ev_note;
            r_evVel      <= ev_velocity;
            r_scanIdx    <= '0;
            r_matchFound <= 1'b0;
            r_freeFound  <= 1'b0;
            r_relFound   <= 1'b0;
            r_heldFound  <= 1'b0;
            r_relAge     <= '0;
            r_heldAge    <= '0;
        end else if (r_state == FSM_SCAN) begin
            r_scanIdx <= r_scanIdx + 1'b1;
            if ((w_scanState == VS_HELD) && (w_scanNote == r_evNote) && !r_matchFound) begin
                r_matchFound <= 1'b1;
                r_matchIdx   <= r_scanIdx;
            end
            if ((w_scanState == VS_FREE) && !r_freeFound) begin
                r_freeFound <= 1'b1;
                r_freeIdx   <= r_scanIdx;
            end
            if ((w_scanState == VS_RELEASING) && (!r_relFound || (w_scanAge > r_relAge))) begin
                r_relFound <= 1'b1;
                r_relIdx   <= r_scanIdx;
                r_relAge   <= w_scanAge;
            end
            if ((w_scanState == VS_HELD) && (!r_heldFound || (w_scanAge > r_heldAge))) begin
                r_heldFound <= 1'b1;
                r_heldIdx   <= r_scanIdx;
                r_heldAge   <= w_scanAge;
            end
        end
    end

    // Note-on target: retrigger > free > oldest releasing > oldest held
    always_comb begin
        if (r_matchFound) begin
            w_target = r_matchIdx;
        end else if (r_freeFound) begin
            w_target = r_freeIdx;
        end else if (r_relFound) begin
            w_target = r_relIdx;
        end else begin
            w_target = r_heldIdx;
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        localparam logic [c_idxW-1:0] c_slotIdx = c_idxW'(i);

        assign w_write[i]   = w_commit && r_evOn && (w_target == c_slotIdx);
        assign w_ageInc[i]  = w_commit && r_evOn && (w_target != c_slotIdx);
        assign w_release[i] = w_commit && !r_evOn && r_matchFound && (r_matchIdx == c_slotIdx);

        voice_slot #(
            .AGE_W (AGE_W)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .i_write       (w_write[i]),
            .i_ageInc      (w_ageInc[i]),
            .i_release     (w_release[i]),
            .i_panic       (panic),
            .i_releaseDone (release_done[i]),
            .i_note        (r_evNote),
            .i_velocity    (r_evVel),
            .o_state       (w_slotState[i]),
            .o_note        (w_slotNote[i]),
            .o_velocity    (w_slotVel[i]),
            .o_age         (w_slotAge[i]),
            .o_gate        (w_gate[i]),
            .o_trig        (w_trig[i])
        );

        assign voice_note[NOTE_W*i +: NOTE_W]    = w_slotNote[i];
        assign voice_velocity[VEL_W*i +: VEL_W]  = w_slotVel[i];
    end

    assign voice_gate = w_gate;
    assign voice_trig = w_trig;

    // Count of occupied voices
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_slotState[i] != VS_FREE) begin
                w_busy = w_busy + 5'd1;
            end
        end
    end

    // Registered occupancy; the 4-bit port saturates when all 16 voices are busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busyCount <= '0;
        end else begin
            r_busyCount <= (w_busy > 5'd15) ? 4'd15 : 4'(w_busy);
        end
    end

    assign busy_count = r_busyCount;

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI byte parser and NUM_VOICES oscillator/envelope voices.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice.
- Steals the oldest voice when none is free.
- Drives per-voice note, velocity, gate and a one-cycle retrigger pulse to the voice datapaths.

Parameters:
- NUM_VOICES, 4, number of voices; 2..16.
- AGE_W, 4, width of per-voice age counter; saturates at 2^AGE_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note / frequency index.
- ev_velocity  in  7  velocity; note-on with 0 is treated as note-off.
- panic  in  1  all-notes-off pulse.
- release_done  in  NUM_VOICES  per-voice pulse: envelope reached zero after gate fell.
- voice_note  out  7*NUM_VOICES  note per voice; voice i at bits [7i+6:7i].
- voice_velocity  out  7*NUM_VOICES  velocity per voice, same packing.
- voice_gate  out  NUM_VOICES  key held.
- voice_trig  out  NUM_VOICES  one-cycle pulse on (re)assignment.
- busy_count  out  4  number of non-FREE voices.

Behaviour:
- Per-voice state: FREE, HELD (gate=1), RELEASING (gate=0, awaiting release_done).
- Reset: all voices FREE; every output zero; ages zero; ev_ready=1 in the cycle after rst deasserts.
- Controller FSM: IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE:
  - ev_ready=1.
  - On ev_valid, latch the event and go to SCAN.
- SCAN:
  - ev_ready=0.
  - Visits voice 0..NUM_VOICES-1, one per cycle (NUM_VOICES cycles).
  - Records the first HELD voice with a matching note.
  - Records the lowest-index FREE voice.
  - Records the oldest RELEASING voice and the oldest HELD voice. Oldest = largest age; ties go to the lowest index (strict > compare).
- COMMIT, note-on:
  - Target priority: matching HELD voice (retrigger) > free > oldest RELEASING > oldest HELD.
  - Write note and velocity; set HELD, gate=1; pulse voice_trig[target] in the COMMIT cycle.
  - Target age := 0; every other non-FREE voice age +1, saturating.
- COMMIT, note-off (including velocity 0):
  - Matching HELD voice goes to RELEASING, gate=0; note and velocity retained.
  - No match: no change.
- Latency: event accepted at cycle t; outputs updated at the clock edge ending cycle t+NUM_VOICES+1; ev_ready high again at t+NUM_VOICES+2.
- release_done[i]:
  - Acts in any FSM state, but only while voice i is RELEASING: voice goes to FREE and age := 0.
  - Ignored in FREE/HELD.
  - If COMMIT targets the same voice in the same cycle, COMMIT wins.
  - During SCAN, the state already sampled for a voice is used; a late free is not rescanned.
- panic:
  - Every HELD voice goes to RELEASING at the next edge.
  - Aborts any SCAN/COMMIT in progress (the event is dropped); FSM returns to IDLE.
  - Takes precedence over release_done only for voices that are HELD.
- rst mid-SCAN: FSM to IDLE, latched event discarded, all voices FREE.
- busy_count: registered; updated the cycle after any state change.
- Outputs are registered; no combinational path from ev_* to voice_*.

Decomposition:
- Shared package synth_pkg:
  - Voice-state encoding (FREE=2'd0, HELD=2'd1, RELEASING=2'd2).
  - FSM state encoding.
  - Widths NOTE_W=7, VEL_W=7.
- One sub-module, voice_slot: per-voice state register, note/velocity registers, age counter, trig pulse.
  - Controlled by write/age-increment/release/panic strobes from the allocator FSM.
  - Instantiated NUM_VOICES times via generate.

Test Plan:
- Reset, then note-on 60 vel 100 -> voice0 note=60 vel=100 gate=1, one trig pulse, output update NUM_VOICES+1 cycles after accept; busy_count=1.
- Note-ons 60, 62, 64, 65, then note-on 67 (NUM_VOICES=4, no releases) -> 67 steals voice0 (oldest): trig[0] pulse, gate stays 1.
- Note-on 60, then note-on 60 vel 0 -> voice0 RELEASING, gate=0, note stays 60; then release_done[0] -> FREE, busy_count=0; a further note-off 60 changes nothing.
- Voice1 RELEASING and voices 0, 2, 3 HELD, new note-on 70 -> voice1 is chosen over older HELD voices; note-on 60 while 60 is HELD in voice2 -> retriggers voice2 only.
- panic asserted mid-SCAN of a note-on -> all gates 0, no trig, event dropped, ev_ready=1 next cycle.
- release_done[2] in the same cycle as a COMMIT targeting voice2 -> voice2 HELD with the new note; rst during SCAN -> all outputs 0 next cycle.
